// File: rtl/config_loader.sv
// config_loader: header/payload word loader that streams weight or bias values to neural-network layers.
//
// Ports:
//   clk               single clock, rising edge
//   rst               asynchronous active-low reset
//   s_valid/s_data    host word stream (header or payload), s_ready accepts it
//   weightValid/Value one-cycle weight strobe and data
//   biasValid/Value   one-cycle bias strobe and data
//   config_layer_num  target layer of the current block, zero-extended
//   config_neuron_num target neuron of the current block, zero-extended
//   busy              block in progress
//   done              one-cycle pulse after the last strobe of a good block
//   err               sticky error (bad header or bad checksum), cleared by reset
//
// Optional feature: define CONFIG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum word after each block's payload.
module config_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [31:0]           s_data,
    output logic                  s_ready,
    output logic                  weightValid,
    output logic                  biasValid,
    output logic [DATA_WIDTH-1:0] weightValue,
    output logic [DATA_WIDTH-1:0] biasValue,
    output logic [31:0]           config_layer_num,
    output logic [31:0]           config_neuron_num,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, DONE, CHK} state_t;
    logic [DATA_WIDTH-1:0] csum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif
    state_t               state;
    logic                 is_bias;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 xfer;
    logic [3:0]           h_type;
    logic [CNT_WIDTH-1:0] h_cnt;
    logic                 hdr_ok;
    // s_ready is held low while rst is asserted and rises once it releases
    assign s_ready = rst && (state != DONE);
    assign xfer    = s_valid && s_ready;
    assign h_type  = s_data[31:28];
    assign h_cnt   = s_data[CNT_WIDTH-1:0];
    // bias blocks carry exactly one value
    assign hdr_ok  = (h_type == 4'd1 || h_type == 4'd2) && h_cnt != '0 &&
                     !(h_type == 4'd2 && h_cnt != CNT_WIDTH'(1));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            is_bias           <= 1'b0;
            cnt               <= '0;
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= '0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum              <= '0;
`endif
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (xfer) begin
                    if (hdr_ok) begin
                        is_bias           <= h_type == 4'd2;
                        cnt               <= h_cnt;
                        config_layer_num  <= {24'd0, s_data[27:20]};
                        config_neuron_num <= {22'd0, s_data[19:10]};
                        busy              <= 1'b1;
                        state             <= LOAD;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum              <= '0;
`endif
                    end else begin
                        err <= 1'b1;
                    end
                end
                LOAD: if (xfer) begin
                    if (is_bias) begin
                        biasValid <= 1'b1;
                        biasValue <= s_data[DATA_WIDTH-1:0];
                    end else begin
                        weightValid <= 1'b1;
                        weightValue <= s_data[DATA_WIDTH-1:0];
                    end
                    cnt <= cnt - 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum <= csum ^ s_data[DATA_WIDTH-1:0];
                    if (cnt == CNT_WIDTH'(1))
                        state <= CHK;
`else
                    if (cnt == CNT_WIDTH'(1))
                        state <= DONE;
`endif
                end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (s_data[DATA_WIDTH-1:0] == csum) begin
                        state <= DONE;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized self-checking bench for config_loader against a block-level reference model.
module tb_config_loader;
    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data  = '0;
    logic        s_ready, weightValid, biasValid, busy, done, err;
    logic [15:0] weightValue, biasValue;
    logic [31:0] config_layer_num, config_neuron_num;

    config_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .weightValid(weightValid), .biasValid(biasValid),
        .weightValue(weightValue), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        b;
        logic [15:0] v;
        int          c;
        logic [31:0] l;
        logic [31:0] n;
    } ev_t;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          both_cnt = 0;
    int          busy_bad = 0;
    ev_t         obs_q[$];
    ev_t         exp_q[$];
    int          obs_done[$];
    int          exp_done[$];
    logic [15:0] fixed_q[$];
    logic        exp_err = 1'b0;
    logic [15:0] last_w = '0;
    logic [15:0] last_b = '0;
    logic [31:0] exp_l = '0;
    logic [31:0] exp_n = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic b, input logic [15:0] v, input int c,
                               input logic [31:0] l, input logic [31:0] n);
        ev_t e;
        e.b = b; e.v = v; e.c = c; e.l = l; e.n = n;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (weightValid && biasValid) both_cnt <= both_cnt + 1;
            if (weightValid) obs_q.push_back(mk(1'b0, weightValue, cyc, config_layer_num, config_neuron_num));
            if (biasValid) obs_q.push_back(mk(1'b1, biasValue, cyc, config_layer_num, config_neuron_num));
            if (done) obs_done.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [31:0] w, output int hs);
        int n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("ready_timeout", s_ready, 1'b1);
        @(negedge clk);
        hs      = cyc;
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic gap(input int lo, input int hi);
        repeat ($urandom_range(lo, hi)) begin
            @(negedge clk);
            if (!busy) busy_bad++;
        end
    endtask

    task automatic check_block();
        int m;
        chk("n_strobes", obs_q.size(), exp_q.size());
        m = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk("strobe_val", {obs_q[i].b, obs_q[i].v}, {exp_q[i].b, exp_q[i].v});
            chk("strobe_cyc", obs_q[i].c, exp_q[i].c);
            chk("strobe_tgt", {obs_q[i].l, obs_q[i].n}, {exp_q[i].l, exp_q[i].n});
        end
        chk("n_done", obs_done.size(), exp_done.size());
        m = obs_done.size() < exp_done.size() ? obs_done.size() : exp_done.size();
        for (int i = 0; i < m; i++) chk("done_cyc", obs_done[i], exp_done[i]);
        chk("err", err, exp_err);
        chk("busy_idle", busy, 1'b0);
        chk("ready_idle", s_ready, 1'b1);
        chk("layer", config_layer_num, exp_l);
        chk("neuron", config_neuron_num, exp_n);
        chk("wval_hold", weightValue, last_w);
        chk("bval_hold", biasValue, last_b);
        chk("strobe_excl", both_cnt, 0);
        chk("busy_in_block", busy_bad, 0);
        busy_bad = 0;
        obs_q.delete(); exp_q.delete(); obs_done.delete(); exp_done.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_flags", {weightValid, biasValid, done, err, busy, weightValue, biasValue}, '0);
        chk("rst_target", {config_layer_num, config_neuron_num}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_err = 1'b0; last_w = '0; last_b = '0; exp_l = '0; exp_n = '0;
        obs_q.delete(); exp_q.delete(); obs_done.delete(); exp_done.delete(); fixed_q.delete();
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1'b1);
    endtask

    task automatic run_block(input int typ, input int layer, input int neuron, input int count,
                             input int gap_lo, input int gap_hi, input bit bad_cs);
        int          hs;
        bit          ok;
        logic [15:0] v;
        logic [15:0] x;
        logic [31:0] hdr;
        x   = '0;
        ok  = (typ == 1 || typ == 2) && count != 0 && !(typ == 2 && count != 1);
        hdr = {typ[3:0], layer[7:0], neuron[9:0], count[9:0]};
        send(hdr, hs);
        chk("busy_hdr", busy, ok);
        if (!ok) begin
            exp_err = 1'b1;
            fixed_q.delete();
        end else begin
            exp_l = layer;
            exp_n = neuron;
            for (int i = 0; i < count; i++) begin
                gap(gap_lo, gap_hi);
                v = fixed_q.size() != 0 ? fixed_q.pop_front() : 16'($urandom);
                x ^= v;
                send({16'($urandom), v}, hs);
                if (!busy) busy_bad++;
                exp_q.push_back(mk(typ == 2, v, hs, exp_l, exp_n));
                if (typ == 2) last_b = v;
                else last_w = v;
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            gap(gap_lo, gap_hi);
            send({16'($urandom), bad_cs ? x ^ 16'h00FF : x}, hs);
            if (bad_cs) exp_err = 1'b1;
            else exp_done.push_back(hs + 1);
`else
            exp_done.push_back(hs + 1);
`endif
        end
        repeat (4) @(negedge clk);
        check_block();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int typ;
        int cnt;
        int hs;
        @(negedge clk);
        do_reset();
        fixed_q = '{16'h0011, 16'h0022, 16'h0033};
        run_block(1, 3, 2, 3, 0, 0, 1'b0);
        fixed_q = '{16'hFFF0};
        run_block(2, 1, 5, 1, 0, 0, 1'b0);
        run_block(3, 7, 7, 1, 0, 0, 1'b0);
        run_block(2, 4, 4, 4, 0, 0, 1'b0);
        run_block(1, 8, 9, 2, 0, 2, 1'b0);
        do_reset();
        run_block(1, 9, 4, 2, 5, 5, 1'b0);
        send({4'h1, 8'd6, 10'd9, 10'd3}, hs);
        send({16'h0, 16'hABCD}, hs);
        @(negedge clk);
        chk("pre_rst_strobe", obs_q.size(), 1);
        do_reset();
        repeat (6) @(negedge clk);
        check_block();
        run_block(1, 6, 9, 3, 0, 1, 1'b0);
`ifdef CONFIG_LOADER_CHECKSUM_EN
        fixed_q = '{16'h000F, 16'h00F0};
        run_block(1, 2, 2, 2, 0, 0, 1'b0);
        do_reset();
        fixed_q = '{16'h000F, 16'h00F0};
        run_block(1, 2, 2, 2, 0, 0, 1'b1);
        do_reset();
`endif
        run_block(1, 255, 1023, 1023, 0, 0, 1'b0);
        repeat (40) begin
            if ($urandom_range(0, 9) == 0) do_reset();
            typ = $urandom_range(0, 3);
            cnt = (typ == 2 && $urandom_range(0, 3) != 0) ? 1 : $urandom_range(0, 6);
            run_block(typ, $urandom_range(0, 255), $urandom_range(0, 1023), cnt, 0,
                      $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
